// File: rtl/usb_upload_sched.sv
// usb_upload_sched: arbitrates ADC and frequency uploads into packets on the shared USB upload FIFO
module usb_upload_sched #(
    parameter int unsigned ADC_LEN  = 1024,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_req,
    input  logic [7:0]  adc_data,
    input  logic        freq_req,
    input  logic [31:0] freq_res,
    input  logic [31:0] freq_high,
    input  logic [31:0] freq_low,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [7:0]  fifo_wdata,
    output logic        adc_done,
    output logic        freq_done,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, HDR, TYPE, LEN_H, LEN_L, PAYLOAD, DONE} state_t;

    localparam logic [15:0] ADC_LEN16 = 16'(ADC_LEN);

    state_t      state_q, state_d;
    logic        adc_pend_q, adc_pend_d;
    logic        freq_pend_q, freq_pend_d;
    logic        last_q, last_d;
    logic [95:0] snap_q, snap_d;
    logic [15:0] cnt_q, cnt_d;
    logic        grant, grant_freq;
    logic [15:0] len;
    logic [6:0]  lsb;

    // State, pending flags, grant history, snapshot and byte counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            adc_pend_q  <= 1'b0;
            freq_pend_q <= 1'b0;
            last_q      <= 1'b1;
            snap_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            adc_pend_q  <= adc_pend_d;
            freq_pend_q <= freq_pend_d;
            last_q      <= last_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
        end
    end

    // Arbitration; last_q doubles as the source of the packet in flight (1 = FREQ)
    always_comb begin
        grant       = (state_q == IDLE) & (adc_pend_q | freq_pend_q);
        grant_freq  = freq_pend_q & (~adc_pend_q | ~last_q);
        adc_pend_d  = (adc_pend_q & ~(grant & ~grant_freq)) | adc_req;
        freq_pend_d = (freq_pend_q & ~(grant & grant_freq)) | freq_req;
        last_d      = grant ? grant_freq : last_q;
        snap_d      = (grant & grant_freq) ? {freq_res, freq_high, freq_low} : snap_q;
        cnt_d       = (state_q == LEN_L) ? 16'd0 :
                      (state_q == PAYLOAD && fifo_wr) ? cnt_q + 16'd1 : cnt_q;
    end

    // Next state: header states step on each accepted write, payload ends on the last byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:                     state_d = grant ? HDR : IDLE;
            HDR, TYPE, LEN_H, LEN_L:  state_d = fifo_wr ? state_t'(state_q + 3'd1) : state_q;
            PAYLOAD:                  state_d = (fifo_wr && cnt_q == len - 16'd1) ? DONE : PAYLOAD;
            default:                  state_d = IDLE;
        endcase
    end

    // Outputs: FIFO write strobe and byte mux, done pulses, busy
    always_comb begin
        len        = last_q ? 16'd12 : ADC_LEN16;
        lsb        = {4'd11 - cnt_q[3:0], 3'b000};
        busy       = state_q != IDLE;
        fifo_wr    = (state_q inside {HDR, TYPE, LEN_H, LEN_L, PAYLOAD}) & ~fifo_full;
        adc_done   = (state_q == DONE) & ~last_q;
        freq_done  = (state_q == DONE) & last_q;
        fifo_wdata = 8'h00;
        case (state_q)
            HDR:     fifo_wdata = HDR_BYTE;
            TYPE:    fifo_wdata = last_q ? 8'h02 : 8'h01;
            LEN_H:   fifo_wdata = len[15:8];
            LEN_L:   fifo_wdata = len[7:0];
            PAYLOAD: fifo_wdata = last_q ? snap_q[lsb +: 8] : adc_data;
            default: fifo_wdata = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_usb_upload_sched.sv
// tb_usb_upload_sched: directed scoreboard bench for the upload scheduler
module tb_usb_upload_sched;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        adc_req = 1'b0, freq_req = 1'b0, fifo_full = 1'b0;
    logic [7:0]  adc_data = 8'd10;
    logic [31:0] freq_res = '0, freq_high = '0, freq_low = '0;
    logic        fifo_wr, adc_done, freq_done, busy;
    logic [7:0]  fifo_wdata;

    int n_chk = 0, n_pass = 0, wr_count = 0, adc_dones = 0, freq_dones = 0, pkt_cnt = 0;
    logic       prev_wr = 1'b0;
    logic [8:0] e;
    logic [8:0] q[$];
    int w0, ad0;

    usb_upload_sched #(.ADC_LEN(4), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .adc_req(adc_req), .adc_data(adc_data),
        .freq_req(freq_req), .freq_res(freq_res), .freq_high(freq_high), .freq_low(freq_low),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .adc_done(adc_done), .freq_done(freq_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 adc_data = adc_data + 8'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_adc();
        q.push_back(9'h0A5); q.push_back(9'h001); q.push_back(9'h000); q.push_back(9'h004);
        repeat (4) q.push_back(9'h100);
    endtask

    task automatic push_freq(input logic [31:0] r, input logic [31:0] h, input logic [31:0] l);
        logic [95:0] s;
        s = {r, h, l};
        q.push_back(9'h0A5); q.push_back(9'h002); q.push_back(9'h000); q.push_back(9'h00C);
        for (int i = 0; i < 12; i++) q.push_back({1'b0, s[95 - 8*i -: 8]});
    endtask

    task automatic wait_cnt(input int na, input int nf, input int nw, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (adc_dones >= na && freq_dones >= nf && wr_count >= nw) break;
            @(negedge clk); #1;
        end
        chk(tag, 32'(adc_dones >= na && freq_dones >= nf && wr_count >= nw), 1);
    endtask

    task automatic do_tie(input logic [31:0] r, input logic [31:0] h, input logic [31:0] l);
        freq_res = r; freq_high = h; freq_low = l;
        @(posedge clk); #1 adc_req = 1'b1; freq_req = 1'b1;
        push_adc();
        push_freq(r, h, l);
        @(posedge clk); #1 adc_req = 1'b0; freq_req = 1'b0;
        wait_cnt(adc_dones + 1, 0, 0, 40, "tie_adc_done");
        chk("tie_first_is_adc", 32'(freq_done), 0);
        chk("gap_done_wr", 32'(fifo_wr), 0);
        @(negedge clk); #1;
        chk("gap_idle_wr", 32'(fifo_wr), 0);
        chk("gap_idle_busy", 32'(busy), 0);
        @(negedge clk); #1;
        chk("gap_hdr_wr", 32'(fifo_wr), 1);
        wait_cnt(0, freq_dones + 1, 0, 40, "tie_freq_done");
        chk("tie_q_empty", q.size(), 0);
    endtask

    // Scoreboard: every accepted write is popped and compared; done pulses check framing
    always @(negedge clk) begin
        if (!reset_n) pkt_cnt = 0;
        if (fifo_wr) begin
            chk("wr_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wdata", 32'(fifo_wdata), 32'(e[8] ? adc_data : e[7:0]));
            end
            pkt_cnt++;
            wr_count++;
        end
        if (adc_done || freq_done) begin
            chk("done_after_wr", 32'(prev_wr), 1);
            chk("pkt_len", pkt_cnt, adc_done ? 8 : 16);
            pkt_cnt = 0;
            if (adc_done) adc_dones++;
            else freq_dones++;
        end
        prev_wr = fifo_wr;
    end

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr", 32'(fifo_wr), 0);
        chk("rst_wdata", 32'(fifo_wdata), 0);
        chk("rst_dones", 32'({adc_done, freq_done}), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        @(posedge clk); #1 adc_req = 1'b1;
        push_adc();
        @(posedge clk); #1 adc_req = 1'b0;
        @(negedge clk); #1;
        chk("lat_idle_wr", 32'(fifo_wr), 0);
        chk("lat_idle_busy", 32'(busy), 0);
        @(negedge clk); #1;
        chk("lat_hdr_wr", 32'(fifo_wr), 1);
        chk("lat_hdr_busy", 32'(busy), 1);
        wait_cnt(1, 0, 0, 40, "adc_alone_done");
        chk("adc_alone_q", q.size(), 0);

        freq_res = 32'h0000C350; freq_high = 32'h11223344; freq_low = 32'h55667788;
        @(posedge clk); #1 freq_req = 1'b1;
        push_freq(freq_res, freq_high, freq_low);
        @(posedge clk); #1 freq_req = 1'b0;
        @(posedge clk); #1 freq_res = 32'hDEADBEEF; freq_high = 32'hCAFEF00D; freq_low = 32'h0BADF00D;
        wait_cnt(1, 1, 0, 60, "freq_alone_done");
        chk("freq_alone_q", q.size(), 0);

        do_tie(32'h01020304, 32'h05060708, 32'h090A0B0C);
        do_tie(32'hF0E0D0C0, 32'hB0A09080, 32'h70605040);

        freq_res = 32'h0000C350; freq_high = 32'h11223344; freq_low = 32'h55667788;
        @(posedge clk); #1 freq_req = 1'b1;
        push_freq(freq_res, freq_high, freq_low);
        w0 = wr_count;
        @(posedge clk); #1 freq_req = 1'b0;
        wait_cnt(0, 0, w0 + 8, 40, "stall_reach");
        @(posedge clk); #1 fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("stall_wr", 32'(fifo_wr), 0);
            chk("stall_wdata", 32'(fifo_wdata), 32'h11);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        @(negedge clk); #1;
        chk("resume_wr", 32'(fifo_wr), 1);
        chk("resume_wdata", 32'(fifo_wdata), 32'h11);
        wait_cnt(0, freq_dones + 1, 0, 40, "stall_done");
        chk("stall_total", wr_count - w0, 16);

        ad0 = adc_dones;
        @(posedge clk); #1 adc_req = 1'b1;
        push_adc();
        w0 = wr_count;
        @(posedge clk); #1 adc_req = 1'b0;
        wait_cnt(0, 0, w0 + 2, 40, "absorb_start");
        repeat (3) begin
            @(posedge clk); #1 adc_req = 1'b1;
            @(posedge clk); #1 adc_req = 1'b0;
        end
        push_adc();
        wait_cnt(ad0 + 2, 0, 0, 80, "absorb_done");
        repeat (20) @(negedge clk);
        #1;
        chk("absorb_count", adc_dones, ad0 + 2);
        chk("absorb_idle", 32'(busy), 0);
        chk("absorb_q", q.size(), 0);

        @(posedge clk); #1 adc_req = 1'b1;
        push_adc();
        w0 = wr_count;
        @(posedge clk); #1 adc_req = 1'b0;
        wait_cnt(0, 0, w0 + 3, 40, "rst_reach");
        adc_req = 1'b1;
        @(posedge clk); #1 adc_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr", 32'(fifo_wr), 0);
        chk("midrst_wdata", 32'(fifo_wdata), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_writes", wr_count, w0 + 3);

        do_tie(32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
